// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute controller for the 8-bit core: owns PC, IR and the Z/C flags,
// sequences instruction fetch, ALU/writeback control and load/store handshakes.
module ctrl_fsm #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [2:0]      alu_func,
    output logic            alu_b_imm,
    input  logic            alu_fz,
    input  logic            alu_fc,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic [2:0]      rf_wa,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic [7:0]      imm8,
    output logic            flag_z,
    output logic            flag_c,
    output logic            halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADI = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hA;
    localparam logic [3:0] OP_BRC = 4'hB;
    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_ST  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            flag_z_q, flag_z_d;
    logic            flag_c_q, flag_c_d;

    logic [3:0] op;
    logic       isAlu;
    logic       isMem;

    assign op    = ir_q[15:12];
    assign isAlu = ~op[3];
    assign isMem = (op == OP_LD) || (op == OP_ST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // imem_req is gated by rst_n so a reset landing mid-fetch drops the request at once.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (isMem)
                    state_d = MEM;
                else if (op == OP_HLT)
                    state_d = HALT;
                else
                    state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                if (isAlu) begin
                    rf_we    = 1'b1;
                    flag_z_d = alu_fz;
                    flag_c_d = alu_fc;
                end else if (op == OP_LDI) begin
                    rf_we = 1'b1;
                end else if ((op == OP_JMP) ||
                             ((op == OP_BRZ) && flag_z_q) ||
                             ((op == OP_BRC) && flag_c_q)) begin
                    pc_d = PC_W'(ir_q[7:0]);
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_ST);
                if (dmem_ack) begin
                    rf_we   = (op == OP_LD);
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign alu_func  = ir_q[14:12];
    assign alu_b_imm = (op == OP_ADI);
    assign rf_ra     = ir_q[11:9];
    assign rf_rb     = ir_q[8:6];
    assign rf_wa     = ir_q[11:9];
    assign imm8      = ir_q[7:0];
    assign wb_sel    = (op == OP_LDI) ? 2'd1 : (op == OP_LD) ? 2'd2 : 2'd0;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign halted    = (state_q == HALT);

endmodule
